// File: rtl/id_ex_stage_pkg.sv
// Shared ALU opcodes, operand-select encodings and ID/EX register layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_ex_stage_pkg;

    localparam int ALU_SELECTION_WIDTH = 4;

    // ALU operation codes as decoded by ID and consumed by the ALU
    localparam logic [ALU_SELECTION_WIDTH-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_SELECTION_WIDTH-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_SELECTION_WIDTH-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_SELECTION_WIDTH-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_SELECTION_WIDTH-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_SELECTION_WIDTH-1:0] ALU_NOR  = 4'd5;
    localparam logic [ALU_SELECTION_WIDTH-1:0] ALU_SLT  = 4'd6;
    localparam logic [ALU_SELECTION_WIDTH-1:0] ALU_SLTU = 4'd7;
    localparam logic [ALU_SELECTION_WIDTH-1:0] ALU_SLL  = 4'd8;
    localparam logic [ALU_SELECTION_WIDTH-1:0] ALU_SRL  = 4'd9;
    localparam logic [ALU_SELECTION_WIDTH-1:0] ALU_SRA  = 4'd10;

    // ALU a-operand select
    localparam logic A_SEL_RS    = 1'b0;
    localparam logic A_SEL_SHAMT = 1'b1;

    // ALU b-operand select
    localparam logic [1:0] B_SEL_RT   = 2'd0;
    localparam logic [1:0] B_SEL_SIMM = 2'd1;
    localparam logic [1:0] B_SEL_ZIMM = 2'd2;
    localparam logic [1:0] B_SEL_UIMM = 2'd3;

    // Hard-wired zero register: never a forwarding target
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Contents of the ID/EX register, excluding the parameterised ALU op
    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic        a_sel;
        logic [1:0]  b_sel;
    } ex_regs_t;

endpackage

// File: rtl/id_ex_stage_fwd.sv
// Operand forwarding mux: newest in-flight result for one source register.
// Latency: combinational.
// Backpressure: none; EX/MEM wins over MEM/WB, register 0 never forwarded.
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [4:0]  reg_num,
    input  logic [31:0] stored_data,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_result,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,
    output logic [31:0] fwd_data
);

    // Pick the youngest producer of reg_num, else the value read in ID
    always_comb begin
        fwd_data = stored_data;
        if (reg_num != REG_ZERO) begin
            if (mem_reg_write && (mem_rd == reg_num)) begin
                fwd_data = mem_result;
            end else if (wb_reg_write && (wb_rd == reg_num)) begin
                fwd_data = wb_result;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Latency: one cycle ID->EX register; ALU operands combinational from it.
// Backpressure: stall holds (refreshing rs/rt data), flush loads a bubble.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int SEL_W = ALU_SELECTION_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [15:0]      id_imm,
    input  logic [4:0]       id_shamt,
    input  logic [SEL_W-1:0] id_alu_s,
    input  logic             id_a_sel,
    input  logic [1:0]       id_b_sel,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic [31:0]      mem_result,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_result,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [SEL_W-1:0] alu_s,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [4:0]       ex_rd,
    output logic [31:0]      ex_store_data,
    output logic             load_use_stall
);

    ex_regs_t         ex_q;
    ex_regs_t         ex_d;
    logic [SEL_W-1:0] alu_s_q;
    logic [31:0]      rs_fwd;
    logic [31:0]      rt_fwd;

    // Next register contents from ID; control is squashed for non-instructions
    always_comb begin
        ex_d           = '0;
        ex_d.valid     = id_valid;
        ex_d.reg_write = id_valid & id_reg_write;
        ex_d.mem_read  = id_valid & id_mem_read;
        ex_d.mem_write = id_valid & id_mem_write;
        ex_d.rd        = id_rd;
        ex_d.rs        = id_rs;
        ex_d.rt        = id_rt;
        ex_d.rs_data   = id_rs_data;
        ex_d.rt_data   = id_rt_data;
        ex_d.imm       = id_imm;
        ex_d.shamt     = id_shamt;
        ex_d.a_sel     = id_a_sel;
        ex_d.b_sel     = id_b_sel;
    end

    // Reset beats flush beats stall; a held stage absorbs retiring results
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            ex_q    <= '0;
            alu_s_q <= '0;
        end else if (stall) begin
            ex_q.rs_data <= rs_fwd;
            ex_q.rt_data <= rt_fwd;
        end else begin
            ex_q    <= ex_d;
            alu_s_q <= id_alu_s;
        end
    end

    fwd_mux u_fwd_rs (
        .reg_num       (ex_q.rs),
        .stored_data   (ex_q.rs_data),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .fwd_data      (rs_fwd)
    );

    fwd_mux u_fwd_rt (
        .reg_num       (ex_q.rt),
        .stored_data   (ex_q.rt_data),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .fwd_data      (rt_fwd)
    );

    // ALU operand selection; shift amount rides on a, the shifted value on b
    always_comb begin
        alu_a = (ex_q.a_sel == A_SEL_SHAMT) ? {27'd0, ex_q.shamt} : rs_fwd;
        alu_b = rt_fwd;
        case (ex_q.b_sel)
            B_SEL_RT:   alu_b = rt_fwd;
            B_SEL_SIMM: alu_b = {{16{ex_q.imm[15]}}, ex_q.imm};
            B_SEL_ZIMM: alu_b = {16'd0, ex_q.imm};
            B_SEL_UIMM: alu_b = {ex_q.imm, 16'd0};
            default:    alu_b = rt_fwd;
        endcase
    end

    // A load in EX whose target is read by the instruction in ID must wait
    always_comb begin
        load_use_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != REG_ZERO) &&
                         id_valid && ((ex_q.rd == id_rs) || (ex_q.rd == id_rt));
    end

    assign alu_s         = alu_s_q;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_rd         = ex_q.rd;
    assign ex_store_data = rt_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int SEL_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [31:0]      id_rs_data, id_rt_data;
    logic [4:0]       id_rs, id_rt, id_rd;
    logic [15:0]      id_imm;
    logic [4:0]       id_shamt;
    logic [SEL_W-1:0] id_alu_s;
    logic             id_a_sel;
    logic [1:0]       id_b_sel;
    logic             id_reg_write, id_mem_read, id_mem_write;
    logic             stall, flush;
    logic             mem_reg_write;
    logic [4:0]       mem_rd;
    logic [31:0]      mem_result;
    logic             wb_reg_write;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_result;
    logic [31:0]      alu_a, alu_b;
    logic [SEL_W-1:0] alu_s;
    logic             ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]       ex_rd;
    logic [31:0]      ex_store_data;
    logic             load_use_stall;

    always #5 clk = ~clk;

    id_ex_stage #(.SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_alu_s(id_alu_s),
        .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .stall(stall), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_rd(ex_rd), .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
    );

    int checks = 0;
    int errors = 0;

    // What the EX stage is holding: the instruction it was handed last
    typedef struct packed {
        logic             valid, rw, mr, mw;
        logic [4:0]       rd, rs, rt;
        logic [31:0]      rsd, rtd;
        logic [15:0]      imm;
        logic [4:0]       shamt;
        logic [SEL_W-1:0] s;
        logic             asel;
        logic [1:0]       bsel;
    } model_t;

    model_t m;

    typedef struct {
        logic [31:0] rs_data, rt_data;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic        a_sel;
        logic [1:0]  b_sel;
        logic [31:0] exp_a, exp_b;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value a source register really has right now, given in-flight writers
    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] stored);
        if (r == 5'd0) return stored;
        if (mem_reg_write && mem_rd == r) return mem_result;
        if (wb_reg_write && wb_rd == r) return wb_result;
        return stored;
    endfunction

    function automatic logic [31:0] exp_b();
        case (m.bsel)
            2'd0:    return fwd(m.rt, m.rtd);
            2'd1:    return 32'($signed(m.imm));
            2'd2:    return 32'(m.imm);
            default: return 32'(m.imm) << 16;
        endcase
    endfunction

    task automatic model_edge();
        model_t n;
        n = m;
        if (!rst || flush) begin
            n = '0;
        end else if (stall) begin
            n.rsd = fwd(m.rs, m.rsd);
            n.rtd = fwd(m.rt, m.rtd);
        end else begin
            n.valid = id_valid;
            n.rw    = id_valid ? id_reg_write : 1'b0;
            n.mr    = id_valid ? id_mem_read : 1'b0;
            n.mw    = id_valid ? id_mem_write : 1'b0;
            n.rd    = id_rd;
            n.rs    = id_rs;
            n.rt    = id_rt;
            n.rsd   = id_rs_data;
            n.rtd   = id_rt_data;
            n.imm   = id_imm;
            n.shamt = id_shamt;
            n.s     = id_alu_s;
            n.asel  = id_a_sel;
            n.bsel  = id_b_sel;
        end
        m = n;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model();
        logic lus;
        lus = m.valid && m.mr && (m.rd != 5'd0) && id_valid && (m.rd == id_rs || m.rd == id_rt);
        chk("r_alu_a", alu_a, m.asel ? 32'(m.shamt) : fwd(m.rs, m.rsd));
        chk("r_alu_b", alu_b, exp_b());
        chk("r_alu_s", 32'(alu_s), 32'(m.s));
        chk("r_ex_valid", 32'(ex_valid), 32'(m.valid));
        chk("r_ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
        chk("r_ex_mem_read", 32'(ex_mem_read), 32'(m.mr));
        chk("r_ex_mem_write", 32'(ex_mem_write), 32'(m.mw));
        chk("r_ex_rd", 32'(ex_rd), 32'(m.rd));
        chk("r_store_data", ex_store_data, fwd(m.rt, m.rtd));
        chk("r_load_use", 32'(load_use_stall), 32'(lus));
    endtask

    task automatic set_defaults();
        rst = 1'b1; id_valid = 1'b0;
        id_rs_data = '0; id_rt_data = '0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_imm = '0; id_shamt = '0; id_alu_s = '0; id_a_sel = 1'b0; id_b_sel = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
        stall = 1'b0; flush = 1'b0;
        mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
    endtask

    initial begin
        m = '0;
        vecs[0] = '{32'd5, 32'd0, 16'hFFFF, 5'd0, 1'b0, 2'd1, 32'd5, 32'hFFFF_FFFF};
        vecs[1] = '{32'd9, 32'd0, 16'h1234, 5'd0, 1'b0, 2'd3, 32'd9, 32'h1234_0000};
        vecs[2] = '{32'd7, 32'd0, 16'h0000, 5'd4, 1'b1, 2'd2, 32'd4, 32'h0000_0000};
        vecs[3] = '{32'd1, 32'd0, 16'h8001, 5'd0, 1'b0, 2'd2, 32'd1, 32'h0000_8001};
        vecs[4] = '{32'd2, 32'hDEAD_BEEF, 16'h0000, 5'd31, 1'b1, 2'd0, 32'd31, 32'hDEAD_BEEF};
        vecs[5] = '{32'd3, 32'd0, 16'h7FFF, 5'd0, 1'b0, 2'd1, 32'd3, 32'h0000_7FFF};

        // Reset with a busy ID stage
        set_defaults();
        rst = 1'b0; id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd4; id_rd = 5'd6;
        id_rs_data = 32'h1111; id_rt_data = 32'h2222; id_imm = 16'hABCD;
        id_alu_s = 4'd5; id_reg_write = 1'b1; id_b_sel = 2'd1;
        tick();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_reg_write", 32'(ex_reg_write), 32'd0);
        chk("rst_alu_s", 32'(alu_s), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_ex_rd", 32'(ex_rd), 32'd0);
        chk("rst_store", ex_store_data, 32'd0);

        // Operand selection table
        for (int i = 0; i < 6; i++) begin
            set_defaults();
            id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2;
            id_rs_data = vecs[i].rs_data; id_rt_data = vecs[i].rt_data;
            id_imm = vecs[i].imm; id_shamt = vecs[i].shamt;
            id_a_sel = vecs[i].a_sel; id_b_sel = vecs[i].b_sel;
            tick();
            chk($sformatf("vec%0d_alu_a", i), alu_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_alu_b", i), alu_b, vecs[i].exp_b);
        end

        // Forwarding priority on rs=3
        set_defaults();
        id_valid = 1'b1; id_rs = 5'd3; id_rs_data = 32'h3;
        tick();
        mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = 32'h11;
        wb_reg_write = 1'b1; wb_rd = 5'd3; wb_result = 32'h22;
        #1 chk("fwd_mem_first", alu_a, 32'h11);
        mem_reg_write = 1'b0;
        #1 chk("fwd_wb", alu_a, 32'h22);
        wb_reg_write = 1'b0;
        #1 chk("fwd_none", alu_a, 32'h3);

        // Register 0 is never forwarded
        set_defaults();
        id_valid = 1'b1; id_rs = 5'd0; id_rt = 5'd0;
        tick();
        mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'h11;
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_result = 32'h22;
        #1 chk("fwd_r0_a", alu_a, 32'd0);
        chk("fwd_r0_store", ex_store_data, 32'd0);

        // Load-use detection
        set_defaults();
        id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd = 5'd4;
        tick();
        id_mem_read = 1'b0; id_rs = 5'd4; id_rt = 5'd6;
        #1 chk("lu_rs", 32'(load_use_stall), 32'd1);
        id_rs = 5'd5; id_rt = 5'd4;
        #1 chk("lu_rt", 32'(load_use_stall), 32'd1);
        id_rt = 5'd6;
        #1 chk("lu_nomatch", 32'(load_use_stall), 32'd0);
        id_valid = 1'b0; id_rs = 5'd4;
        #1 chk("lu_id_invalid", 32'(load_use_stall), 32'd0);

        set_defaults();
        id_valid = 1'b1; id_mem_read = 1'b1; id_rd = 5'd0;
        tick();
        id_mem_read = 1'b0; id_rs = 5'd0;
        #1 chk("lu_rd0", 32'(load_use_stall), 32'd0);

        set_defaults();
        id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd = 5'd4;
        tick();
        id_mem_read = 1'b0; id_rs = 5'd4;
        #1 chk("lu_before_flush", 32'(load_use_stall), 32'd1);
        flush = 1'b1;
        tick();
        chk("flush_ex_valid", 32'(ex_valid), 32'd0);
        chk("flush_mem_read", 32'(ex_mem_read), 32'd0);
        chk("flush_reg_write", 32'(ex_reg_write), 32'd0);
        chk("flush_lu", 32'(load_use_stall), 32'd0);

        // Writeback retiring during a stall is captured
        set_defaults();
        id_valid = 1'b1; id_rt = 5'd7; id_rt_data = 32'd0; id_reg_write = 1'b1; id_rd = 5'd9;
        tick();
        stall = 1'b1; id_rt = 5'd3; id_rt_data = 32'h55; id_rd = 5'd2;
        wb_reg_write = 1'b1; wb_rd = 5'd7; wb_result = 32'h99;
        tick();
        wb_reg_write = 1'b0;
        tick();
        stall = 1'b0;
        #1 chk("stall_store", ex_store_data, 32'h99);
        chk("stall_alu_b", alu_b, 32'h99);
        chk("stall_hold_rd", 32'(ex_rd), 32'd9);
        chk("stall_hold_valid", 32'(ex_valid), 32'd1);

        // flush together with stall gives a bubble
        set_defaults();
        id_valid = 1'b1; id_reg_write = 1'b1; id_rd = 5'd5; flush = 1'b1; stall = 1'b1;
        tick();
        chk("fs_ex_valid", 32'(ex_valid), 32'd0);
        chk("fs_reg_write", 32'(ex_reg_write), 32'd0);
        chk("fs_ex_rd", 32'(ex_rd), 32'd0);

        // reset during a stall clears the stage
        set_defaults();
        id_valid = 1'b1; id_reg_write = 1'b1; id_rd = 5'd5; id_alu_s = 4'd3;
        tick();
        chk("pre_rst_valid", 32'(ex_valid), 32'd1);
        stall = 1'b1; rst = 1'b0;
        tick();
        chk("rs_ex_valid", 32'(ex_valid), 32'd0);
        chk("rs_ex_rd", 32'(ex_rd), 32'd0);
        chk("rs_alu_s", 32'(alu_s), 32'd0);

        // Randomised traffic against the reference model
        set_defaults();
        tick();
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 31) != 0);
            id_valid      = ($urandom_range(0, 3) != 0);
            id_rs_data    = $urandom;
            id_rt_data    = $urandom;
            id_rs         = 5'($urandom_range(0, 7));
            id_rt         = 5'($urandom_range(0, 7));
            id_rd         = 5'($urandom_range(0, 7));
            id_imm        = 16'($urandom);
            id_shamt      = 5'($urandom);
            id_alu_s      = SEL_W'($urandom);
            id_a_sel      = 1'($urandom);
            id_b_sel      = 2'($urandom);
            id_reg_write  = 1'($urandom);
            id_mem_read   = 1'($urandom);
            id_mem_write  = 1'($urandom);
            stall         = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            mem_reg_write = 1'($urandom);
            mem_rd        = 5'($urandom_range(0, 7));
            mem_result    = $urandom;
            wb_reg_write  = 1'($urandom);
            wb_rd         = 5'($urandom_range(0, 7));
            wb_result     = $urandom;
            #1 check_model();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-forwarding stage that feeds the ALU. It captures decoded operands and control from ID and selects the immediate or shift-amount operand. It resolves EX/MEM and MEM/WB data hazards by forwarding, and drives the ALU `a`, `b` and `s` inputs. It also detects load-use hazards for the pipeline hazard controller.

## Interface
- `SEL_W`, default 4: ALU selection width; equals `ALU_SELECTION_WIDTH`.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs_data`, `id_rt_data`  in  32  register-file read data.
- `id_rs`, `id_rt`, `id_rd`  in  5  source and destination register numbers.
- `id_imm`  in  16  instruction immediate.
- `id_shamt`  in  5  shift amount.
- `id_alu_s`  in  SEL_W  ALU operation.
- `id_a_sel`  in  1  0 = rs, 1 = zero-extended shamt.
- `id_b_sel`  in  2  0 = rt, 1 = sign-extended imm, 2 = zero-extended imm, 3 = {imm, 16'b0}.
- `id_reg_write`, `id_mem_read`, `id_mem_write`  in  1  control bits.
- `stall`  in  1  hold register contents.
- `flush`  in  1  load a bubble.
- `mem_reg_write`  in  1, `mem_rd`  in  5, `mem_result`  in  32  EX/MEM forwarding source.
- `wb_reg_write`  in  1, `wb_rd`  in  5, `wb_result`  in  32  MEM/WB forwarding source.
- `alu_a`, `alu_b`  out  32  ALU operands.
- `alu_s`  out  SEL_W  ALU operation.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1  registered control.
- `ex_rd`  out  5  destination register.
- `ex_store_data`  out  32  forwarded rt, for stores.
- `load_use_stall`  out  1  load-use hazard detected.

## Operation
- **Register update priority** per edge:
  - `rst`=0: all fields cleared.
  - Else `flush`=1: bubble, i.e. all fields 0, so `ex_valid`, `ex_reg_write`, `ex_mem_read` and `ex_mem_write` are 0.
  - Else `stall`=1: hold.
  - Else: load ID fields.
- **Control gating:** when `id_valid`=0, control bits load as 0.
- **Stall refresh:** while held, stored rs/rt data are overwritten with the current forwarded values. A writeback retiring during a stall is therefore not lost.
- **Forwarding (combinational, per source operand):**
  - Use `mem_result` if `mem_reg_write` and `mem_rd`==reg and reg≠0.
  - Else use `wb_result` if `wb_reg_write` and `wb_rd`==reg and reg≠0.
  - Else use the stored value. Register 0 is never forwarded.
- **alu_a:**
  - `a_sel`=0: forwarded rs.
  - `a_sel`=1: {27'b0, shamt}.
  - Variable shifts use rs with `a_sel`=0. The ALU shifts `b` by `a`.
- **alu_b:**
  - `b_sel`=0: forwarded rt.
  - `b_sel`=1: {{16{imm[15]}}, imm}.
  - `b_sel`=2: {16'b0, imm}.
  - `b_sel`=3: {imm, 16'b0}.
- **ex_store_data:** always forwarded rt.
- **load_use_stall:** `ex_valid` & `ex_mem_read` & `ex_rd`≠0 & `id_valid` & (`ex_rd`==`id_rs` | `ex_rd`==`id_rt`).
  - The top level responds by stalling IF/ID and asserting `flush` here next edge.

## Timing
- One-cycle latency: ID values presented at edge N appear on `ex_*`, `alu_*` from edge N.
- `alu_a`, `alu_b`, `ex_store_data` and `load_use_stall` are combinational from the register contents plus same-cycle `mem_*`/`wb_*`/`id_*` inputs. There are no extra cycles.
- Reset value of every output is 0, except `alu_a`, `alu_b` and `ex_store_data`. Those equal the forwarded value of register 0, which is 0.
- Reset asserted mid-stall or mid-flush: reset wins and clears the register within one edge.
- `flush` and `stall` asserted together: bubble.

## Structure
- Shared package/macro file holds:
  - the ALU op codes already used by the ALU;
  - `A_SEL_*`/`B_SEL_*` encodings;
  - the register-0 constant.
- One sub-module: `fwd_mux` (reg number, stored data, mem/wb sources → forwarded data), instanced for rs and rt.

## Test plan
- **Reset:** `rst`=0 for 1 edge with nonzero ID inputs → `ex_valid`=0, `ex_reg_write`=0, `alu_s`=0, `alu_a`=`alu_b`=0.
- **Operand select:**
  - `rs_data`=5, `imm`=0xFFFF, `b_sel`=1 → `alu_a`=5, `alu_b`=0xFFFFFFFF.
  - `b_sel`=3, `imm`=0x1234 → `alu_b`=0x12340000.
  - `a_sel`=1, `shamt`=4 → `alu_a`=4.
- **Forward priority:** stored rs=3, `mem_rd`=3/0x11, `wb_rd`=3/0x22, both writing → `alu_a`=0x11.
  - `mem_reg_write`=0 → 0x22.
  - rs=0 with `mem_rd`=0 → `alu_a`=stored 0.
- **Load-use:** EX `mem_read`=1, `ex_rd`=4, `id_rs`=4 → `load_use_stall`=1.
  - `ex_rd`=0 → 0.
  - Next edge with `flush`=1 → `ex_valid`=0.
- **Stall refresh:** EX holds rt=7 (data 0); `stall`=1 for 2 cycles; `wb` writes r7=0x99 in cycle 1 only → after release `ex_store_data`=0x99.
- **Simultaneous:** `flush`=`stall`=1 with valid ID → bubble. `rst`=0 with `stall`=1 → cleared.
